// File: rtl/aes_pkg.sv
// Shared definitions for the AES block-mode controller: block width,
// chaining-mode encodings and controller FSM state encodings.
package aes_pkg;

  localparam int BLK_W = 128;

  typedef logic [BLK_W-1:0] blk_t;

  // Chaining modes (encrypt direction only)
  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CFB = 2'b10;
  localparam logic [1:0] MODE_OFB = 2'b11;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/aes_mode_mux.sv
// Mode-indexed routing for the block-cipher chaining modes. Selects the
// block presented to the AES core, the ciphertext leaving the controller
// and the next chaining/feedback value. Purely combinational.
module aes_mode_mux
  import aes_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [BLK_W-1:0] new_blk,     // plaintext being accepted now
  input  logic [BLK_W-1:0] held_blk,    // plaintext of the block in flight
  input  logic [BLK_W-1:0] chain,       // current chaining value (IV / feedback)
  input  logic [BLK_W-1:0] core_ct,     // raw AES core output
  output logic [BLK_W-1:0] core_pt,
  output logic [BLK_W-1:0] out_blk,
  output logic [BLK_W-1:0] chain_next
);

  // Per-mode selection of core input, block output and feedback
  always_comb begin
    core_pt    = new_blk;
    out_blk    = core_ct;
    chain_next = chain;
    case (mode)
      MODE_ECB: begin
        core_pt    = new_blk;
        out_blk    = core_ct;
        chain_next = chain;
      end
      MODE_CBC: begin
        core_pt    = new_blk ^ chain;
        out_blk    = core_ct;
        chain_next = core_ct;
      end
      MODE_CFB: begin
        core_pt    = chain;
        out_blk    = core_ct ^ held_blk;
        chain_next = core_ct ^ held_blk;
      end
      MODE_OFB: begin
        core_pt    = chain;
        out_blk    = core_ct ^ held_blk;
        chain_next = core_ct;
      end
      default: begin
        core_pt    = new_blk;
        out_blk    = core_ct;
        chain_next = chain;
      end
    endcase
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// AES block-mode controller. Accepts one plaintext block at a time, feeds
// an external AES-128 encrypt core and applies ECB/CBC/CFB-128/OFB chaining
// to produce the ciphertext stream. Only one block is ever in flight.
module aes_mode_ctrl
  import aes_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [1:0]           mode,
  input  logic [BLK_W-1:0]     key,
  input  logic [BLK_W-1:0]     iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLK_W-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLK_W-1:0]     out_data,
  output logic                 core_start,
  output logic [BLK_W-1:0]     core_plaintext,
  output logic [BLK_W-1:0]     core_key,
  input  logic [BLK_W-1:0]     core_ciphertext,
  input  logic                 core_done,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_count
);

  logic [1:0]       state;
  logic             cfg_valid;
  logic [1:0]       mode_r;
  logic [BLK_W-1:0] chain_r;
  logic [BLK_W-1:0] data_r;
  logic             in_fire;
  logic             cfg_fire;
  logic             done_fire;
  logic [BLK_W-1:0] mux_pt;
  logic [BLK_W-1:0] mux_out;
  logic [BLK_W-1:0] mux_chain;

  // A configuration load in IDLE takes priority over an offered block.
  assign in_ready   = (state == ST_IDLE) && cfg_valid && !cfg_load;
  assign in_fire    = in_valid && in_ready;
  assign cfg_fire   = (state == ST_IDLE) && cfg_load;
  assign done_fire  = (state == ST_WAIT) && core_done;
  assign out_valid  = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);
  // ISSUE lasts exactly one cycle once the core has dropped done, so this
  // is a single-cycle pulse per block.
  assign core_start = (state == ST_ISSUE) && !core_done;

  aes_mode_mux u_mode_mux (
    .mode       (mode_r),
    .new_blk    (in_data),
    .held_blk   (data_r),
    .chain      (chain_r),
    .core_ct    (core_ciphertext),
    .core_pt    (mux_pt),
    .out_blk    (mux_out),
    .chain_next (mux_chain)
  );

  // Control: FSM sequencing, configuration-valid flag and block counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_valid <= 1'b0;
      blk_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            cfg_valid <= 1'b1;
            blk_count <= '0;
          end else if (in_fire) begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!core_done) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) state <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            blk_count <= blk_count + BLK_CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: configuration capture, block capture, core input and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r         <= MODE_ECB;
      core_key       <= '0;
      chain_r        <= '0;
      data_r         <= '0;
      core_plaintext <= '0;
      out_data       <= '0;
    end else begin
      if (cfg_fire) begin
        mode_r   <= mode;
        core_key <= key;
        chain_r  <= iv;
      end else if (in_fire) begin
        data_r         <= in_data;
        core_plaintext <= mux_pt;
      end
      if (done_fire) begin
        out_data <= mux_out;
        chain_r  <= mux_chain;
      end
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: a behavioural AES-128 core drives the core-side
// ports, a textbook chaining-mode model predicts every ciphertext, and a
// per-cycle monitor compares handshakes, counters and data against it.
module tb_aes_mode_ctrl;
  import aes_pkg::*;

  localparam int CW = 2;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CBC1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CFB1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] CFB2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
  localparam logic [127:0] OFB1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] OFB2 = 128'h7789508d16918f03f53c52dac54ed825;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_load = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [127:0]  key = '0;
  logic [127:0]  iv = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [127:0]  out_data;
  logic          core_start;
  logic [127:0]  core_plaintext;
  logic [127:0]  core_key;
  logic [127:0]  core_ciphertext = '0;
  logic          core_done = 1'b0;
  logic          busy;
  logic [CW-1:0] blk_count;

  always #5 clk = ~clk;

  aes_mode_ctrl #(.BLK_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .mode(mode), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .core_done(core_done),
    .busy(busy), .blk_count(blk_count)
  );

  logic [7:0]   sbox [256];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           acc_cnt = 0;
  int           done_cnt = 0;
  int           drop_cnt = 0;
  int           base_cnt = 0;
  int           n_start = 0;
  int           core_lat = 1;
  logic         cfg_ok = 1'b0;
  logic [1:0]   mdl_mode = 2'b00;
  logic [127:0] mdl_key = '0;
  logic [127:0] mdl_chain = '0;
  logic [127:0] exp_arr [64];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference AES-128 encryption straight from the FIPS-197 round description
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Behavioural AES core: done pulses for one cycle core_lat+1 cycles after
  // start; ciphertext carries junk whenever done is low.
  logic         core_pend = 1'b0;
  int           core_dly = 0;
  logic [127:0] core_res = '0;
  always @(posedge clk) begin
    core_done       <= 1'b0;
    core_ciphertext <= ~core_res;
    if (core_start === 1'b1) begin
      core_pend <= 1'b1;
      core_dly  <= core_lat;
      core_res  <= aes_enc(core_key, core_plaintext);
    end else if (core_pend) begin
      if (core_dly == 0) begin
        core_pend       <= 1'b0;
        core_done       <= 1'b1;
        core_ciphertext <= core_res;
      end else begin
        core_dly <= core_dly - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Textbook mode definitions applied to the model's chaining state
  task automatic model_block(input logic [127:0] pt, output logic [127:0] ct);
    logic [127:0] o;
    case (mdl_mode)
      MODE_ECB: ct = aes_enc(mdl_key, pt);
      MODE_CBC: begin ct = aes_enc(mdl_key, pt ^ mdl_chain); mdl_chain = ct; end
      MODE_CFB: begin ct = pt ^ aes_enc(mdl_key, mdl_chain); mdl_chain = ct; end
      default:  begin o = aes_enc(mdl_key, mdl_chain); ct = pt ^ o; mdl_chain = o; end
    endcase
  endtask

  // Per-cycle comparison of the DUT against the model's bookkeeping
  task automatic monitor();
    logic          exp_rdy, inflight;
    logic [CW-1:0] exp_cnt;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inflight = (acc_cnt != done_cnt + drop_cnt);
        exp_rdy  = cfg_ok && !inflight && !cfg_load;
        exp_cnt  = CW'(done_cnt - base_cnt);
        chk("mon_in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("mon_busy", 128'(busy), 128'(inflight));
        chk("mon_blk_count", 128'(blk_count), 128'(exp_cnt));
        if (core_start) begin
          n_start++;
          chk("mon_core_key", core_key, mdl_key);
        end
        if (out_valid) begin
          if (!inflight) begin
            chk("mon_spurious_out_valid", 128'(out_valid), 128'(1'b0));
          end else begin
            chk("mon_out_data", out_data, exp_arr[done_cnt + drop_cnt]);
            if (out_ready) begin
              chk("mon_starts_per_block", 128'(n_start), 128'(done_cnt + drop_cnt + 1));
              done_cnt++;
            end
          end
        end
      end
    end
  endtask

  // All driver tasks start and end just after a rising edge
  task automatic do_cfg(input logic [1:0] m, input logic [127:0] k, input logic [127:0] v,
                        input logic apply);
    cfg_load = 1'b1; mode = m; key = k; iv = v;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    if (apply) begin
      mdl_mode = m; mdl_key = k; mdl_chain = v;
      base_cnt = done_cnt; cfg_ok = 1'b1;
    end
  endtask

  task automatic send_block(input logic [127:0] pt);
    int i;
    logic [127:0] ct;
    in_valid = 1'b1; in_data = pt;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (i == 200) begin
      chk("send_timeout", 128'(in_ready), 128'(1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      model_block(pt, ct);
      exp_arr[acc_cnt] = ct;
      @(posedge clk); #1;
      acc_cnt++;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output logic [127:0] ct);
    int i;
    ct = '0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) break;
    end
    if (i == 200) chk("out_timeout", 128'(out_valid), 128'(1'b1));
    else ct = out_data;
    @(posedge clk); #1;
  endtask

  task automatic run_pair(input logic [1:0] m, input logic [127:0] e1, input logic [127:0] e2,
                          input string nm);
    logic [127:0] ct;
    do_cfg(m, K1, IV1, 1'b1);
    send_block(P1); wait_out(ct); chk({nm, "_blk1"}, ct, e1);
    send_block(P2); wait_out(ct); chk({nm, "_blk2"}, ct, e2);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, "_out_valid"}, 128'(out_valid), 128'(1'b0));
    chk({nm, "_in_ready"}, 128'(in_ready), 128'(1'b0));
    chk({nm, "_busy"}, 128'(busy), 128'(1'b0));
    chk({nm, "_core_start"}, 128'(core_start), 128'(1'b0));
    chk({nm, "_blk_count"}, 128'(blk_count), 128'(0));
    chk({nm, "_out_data"}, out_data, 128'h0);
    chk({nm, "_core_pt"}, core_plaintext, 128'h0);
    chk({nm, "_core_key"}, core_key, 128'h0);
  endtask

  initial begin
    logic [7:0]   inv;
    logic [127:0] ct, d0;
    logic [CW-1:0] cnt_seq [5];
    int i, n_ov;
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    chk("model_sbox_00", 128'(sbox[0]), 128'h63);
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
    chk("model_fips197", aes_enc(K0, P0), C0);

    fork monitor(); join_none

    // Reset state and no acceptance before configuration
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = P0;
    repeat (4) @(negedge clk);
    chk("nocfg_in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // FIPS-197 ECB with latency checks
    core_lat = 2;
    do_cfg(MODE_ECB, K0, 128'h0, 1'b1);
    send_block(P0);
    @(negedge clk);
    chk("lat_core_start", 128'(core_start), 128'(1'b1));
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_done) break;
    end
    chk("lat_core_done_seen", 128'(core_done), 128'(1'b1));
    @(negedge clk);
    chk("lat_out_valid", 128'(out_valid), 128'(1'b1));
    chk("ecb_fips", out_data, C0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ecb_blk_count", 128'(blk_count), 128'(1));
    @(posedge clk); #1;

    // SP800-38A vectors
    core_lat = 1;
    run_pair(MODE_CBC, CBC1, CBC2, "cbc");
    run_pair(MODE_CFB, CFB1, CFB2, "cfb");
    run_pair(MODE_OFB, OFB1, OFB2, "ofb");

    // cfg_load wins over a simultaneous in_valid; new iv takes effect
    cfg_load = 1'b1; mode = MODE_CBC; key = K1; iv = IV1;
    in_valid = 1'b1; in_data = P1;
    @(negedge clk);
    chk("cfgwin_in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk); #1;
    cfg_load = 1'b0;
    mdl_mode = MODE_CBC; mdl_key = K1; mdl_chain = IV1; base_cnt = done_cnt;
    send_block(P1); wait_out(ct);
    chk("cfgwin_cbc1", ct, CBC1);

    // Backpressure for 20 cycles, with an ignored cfg_load while busy
    out_ready = 1'b0;
    send_block(P2);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    d0 = out_data;
    chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
    @(posedge clk); #1;
    do_cfg(MODE_ECB, ~K1, ~IV1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_stable", out_data, d0);
      chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out(ct);
    chk("bp_cbc2", ct, CBC2);
    chk("bp_single_start", 128'(n_start), 128'(acc_cnt));

    // Reset while waiting on the core, then a late core_done
    core_lat = 15;
    send_block(P1);
    repeat (3) @(negedge clk);
    chk("rstwait_busy", 128'(busy), 128'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    drop_cnt = acc_cnt - done_cnt; base_cnt = done_cnt; cfg_ok = 1'b0;
    @(negedge clk);
    reset_values("rstwait");
    @(posedge clk); #1;
    rst = 1'b0;
    n_ov = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    chk("late_done_no_out", 128'(n_ov), 128'(0));
    @(posedge clk); #1;
    core_lat = 1;
    run_pair(MODE_CBC, CBC1, CBC2, "post_rst_cbc");

    // Narrow counter wraps
    do_cfg(MODE_ECB, K0, 128'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send_block(P0 ^ 128'(k));
      wait_out(ct);
      @(negedge clk);
      chk("wrap_blk_count", 128'(blk_count), 128'(cnt_seq[k]));
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
